// File: rtl/sc_posjug2_lanectrl_pkg.sv
// sc_posjug2_pkg: shared lane-controller types and the lane count used by the player-2 comparator.
package sc_posjug2_pkg;
    typedef enum logic [1:0] {IDLE, HOLD, FROZEN} state_t;
    typedef enum logic [1:0] {NONE, LEFT, RIGHT} dir_t;
    localparam int NUM_LANES_DEF = 4;
endpackage

// File: rtl/sc_posjug2_lanectrl_if.sv
// sc_posjug2_lanectrl_if: button/flag inputs and position/freeze outputs of the player-2 lane controller.
interface sc_posjug2_lanectrl_if #(parameter int DATAWIDTH = 8);
    logic                 SC_POSJUG2_LANECTRL_left_InHigh;
    logic                 SC_POSJUG2_LANECTRL_right_InHigh;
    logic                 SC_POSJUG2_LANECTRL_enable_InHigh;
    logic                 SC_POSJUG2_LANECTRL_clear_InHigh;
    logic                 SC_POSJUG2_LANECTRL_nocollision;
    logic [DATAWIDTH-1:0] SC_POSJUG2_LANECTRL_posjug2;
    logic                 SC_POSJUG2_LANECTRL_Frozen;
    modport master (
        output SC_POSJUG2_LANECTRL_left_InHigh, SC_POSJUG2_LANECTRL_right_InHigh,
               SC_POSJUG2_LANECTRL_enable_InHigh, SC_POSJUG2_LANECTRL_clear_InHigh,
               SC_POSJUG2_LANECTRL_nocollision,
        input  SC_POSJUG2_LANECTRL_posjug2, SC_POSJUG2_LANECTRL_Frozen
    );
    modport slave (
        input  SC_POSJUG2_LANECTRL_left_InHigh, SC_POSJUG2_LANECTRL_right_InHigh,
               SC_POSJUG2_LANECTRL_enable_InHigh, SC_POSJUG2_LANECTRL_clear_InHigh,
               SC_POSJUG2_LANECTRL_nocollision,
        output SC_POSJUG2_LANECTRL_posjug2, SC_POSJUG2_LANECTRL_Frozen
    );
endinterface

// File: rtl/sc_posjug2_lanectrl_repeat_timer.sv
// sc_repeat_timer: load/decrement down-counter with zero flag, paces hold-to-repeat moves.
module sc_repeat_timer #(
    parameter int REPEAT_CYCLES = 12_500_000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_load,
    input  logic i_dec,
    output logic o_zero
);
    localparam int W = REPEAT_CYCLES > 1 ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [W-1:0] RELOAD = W'(REPEAT_CYCLES - 1);
    logic [W-1:0] r_cnt;
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clr) r_cnt <= '0;
        else if (i_load)       r_cnt <= RELOAD;
        else if (i_dec)        r_cnt <= r_cnt - W'(1);
    end
    assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/sc_posjug2_lanectrl.sv
// sc_posjug2_lanectrl: one-hot player-2 lane register driven by left/right buttons with
// hold-to-repeat, outer-lane saturation and freeze on collision.
module sc_posjug2_lanectrl
    import sc_posjug2_pkg::*;
#(
    parameter int DATAWIDTH     = 8,
    parameter int NUM_LANES     = NUM_LANES_DEF,
    parameter int START_LANE    = 0,
    parameter int REPEAT_CYCLES = 12_500_000
) (
    input  logic                   SC_POSJUG2_LANECTRL_CLOCK_50,
    input  logic                   SC_POSJUG2_LANECTRL_RESET_InLow,
    sc_posjug2_lanectrl_if.slave   lane
);
    localparam logic [DATAWIDTH-1:0] START_POS = DATAWIDTH'(1) << START_LANE;

    state_t               r_state;
    dir_t                 r_dir;
    logic [DATAWIDTH-1:0] r_pos;
    logic                 r_frozen;
    dir_t                 w_dir;
    logic                 w_clr, w_live, w_move, w_dec, w_zero;

    // Saturating one-hot shift: LEFT climbs toward bit NUM_LANES-1, RIGHT toward bit 0.
    function automatic logic [DATAWIDTH-1:0] f_step(input logic [DATAWIDTH-1:0] p, input dir_t d);
        return d == LEFT  ? (p[NUM_LANES-1] ? p : p << 1) :
               d == RIGHT ? (p[0] ? p : p >> 1) : p;
    endfunction

    always_comb begin
        w_dir  = (lane.SC_POSJUG2_LANECTRL_left_InHigh && !lane.SC_POSJUG2_LANECTRL_right_InHigh) ? LEFT :
                 (lane.SC_POSJUG2_LANECTRL_right_InHigh && !lane.SC_POSJUG2_LANECTRL_left_InHigh) ? RIGHT : NONE;
        w_clr  = !SC_POSJUG2_LANECTRL_RESET_InLow || lane.SC_POSJUG2_LANECTRL_clear_InHigh;
        w_live = lane.SC_POSJUG2_LANECTRL_enable_InHigh && lane.SC_POSJUG2_LANECTRL_nocollision && r_state != FROZEN;
        w_move = w_live && w_dir != NONE && (r_state == IDLE || w_dir != r_dir || w_zero);
        w_dec  = w_live && r_state == HOLD && w_dir == r_dir && !w_zero;
    end

    sc_repeat_timer #(.REPEAT_CYCLES(REPEAT_CYCLES)) u_timer (
        .i_clk   (SC_POSJUG2_LANECTRL_CLOCK_50),
        .i_rst_n (SC_POSJUG2_LANECTRL_RESET_InLow),
        .i_clr   (lane.SC_POSJUG2_LANECTRL_clear_InHigh),
        .i_load  (w_move),
        .i_dec   (w_dec),
        .o_zero  (w_zero)
    );

    always_ff @(posedge SC_POSJUG2_LANECTRL_CLOCK_50) begin
        if (w_clr) begin
            r_pos    <= START_POS;
            r_state  <= IDLE;
            r_dir    <= NONE;
            r_frozen <= 1'b0;
        end else if (r_state != FROZEN) begin
            if (!lane.SC_POSJUG2_LANECTRL_enable_InHigh) begin
                r_state <= IDLE;
            end else if (!lane.SC_POSJUG2_LANECTRL_nocollision) begin
                r_state  <= FROZEN;
                r_frozen <= 1'b1;
            end else if (w_dir == NONE) begin
                r_state <= IDLE;
            end else if (w_move) begin
                r_pos   <= f_step(r_pos, w_dir);
                r_dir   <= w_dir;
                r_state <= HOLD;
            end
        end
    end

    assign lane.SC_POSJUG2_LANECTRL_posjug2 = r_pos;
    assign lane.SC_POSJUG2_LANECTRL_Frozen  = r_frozen;
endmodule

// File: doc/sc_posjug2_lanectrl.md
# sc_posjug2_lanectrl

Player-2 lane controller: converts debounced left/right button levels into the one-hot player-2 position bus that feeds the player-2 position/obstacle collision comparator. Moves one lane per press with hold-to-repeat, saturates at the outer lanes, and freezes on the active-low no-collision flag returned by that comparator. Sits between the button debouncers and the player-2 collision comparator; `Frozen` goes to the game-control FSM.

## Interface
- `DATAWIDTH`, 8, position bus width; must match the comparator.
- `NUM_LANES`, 4, active lanes, bits [NUM_LANES-1:0]; 2 ≤ NUM_LANES ≤ DATAWIDTH.
- `START_LANE`, 0, lane index loaded on reset/clear.
- `REPEAT_CYCLES`, 12_500_000, hold cycles between auto-repeat moves (0.25 s @ 50 MHz); ≥ 2.
- `SC_POSJUG2_LANECTRL_CLOCK_50`  in  1  system clock, rising edge.
- `SC_POSJUG2_LANECTRL_RESET_InLow`  in  1  synchronous reset, active low.
- `SC_POSJUG2_LANECTRL_left_InHigh`  in  1  debounced left button level.
- `SC_POSJUG2_LANECTRL_right_InHigh`  in  1  debounced right button level.
- `SC_POSJUG2_LANECTRL_enable_InHigh`  in  1  game running.
- `SC_POSJUG2_LANECTRL_clear_InHigh`  in  1  new-game pulse.
- `SC_POSJUG2_LANECTRL_nocollision`  in  1  comparator output: 1 = clear, 0 = collision.
- `SC_POSJUG2_LANECTRL_posjug2`  out  DATAWIDTH  registered one-hot position; bits ≥ NUM_LANES always 0.
- `SC_POSJUG2_LANECTRL_Frozen`  out  1  registered, 1 while in FROZEN.

## Operation
- Decided: one clock; reset synchronous, active low.
- Reset: posjug2 = 1<<START_LANE, Frozen = 0, state IDLE, repeat counter 0.
- Direction: `dir` = LEFT if left&!right, RIGHT if right&!left, NONE otherwise (both pressed = NONE). LEFT = toward bit NUM_LANES-1, RIGHT = toward bit 0. Saturate at lanes NUM_LANES-1 and 0; never wrap. Saturated press still enters HOLD; position unchanged.
- States: IDLE, HOLD, FROZEN. Priority each cycle: reset > clear > freeze > move.
- clear=1 (any state): posjug2 = START_LANE, state IDLE, counter 0, Frozen 0.
- enable=0: no moves, no freeze; IDLE/HOLD → IDLE; FROZEN stays FROZEN; position held.
- Freeze: enable=1 and nocollision=0 in IDLE or HOLD → FROZEN; no move that cycle. FROZEN exits only via clear or reset; buttons ignored.
- IDLE, dir≠NONE: move one lane, latch dir, counter ← REPEAT_CYCLES-1, → HOLD.
- HOLD, dir = latched dir: counter decrements; when counter is 0, move one lane and reload REPEAT_CYCLES-1.
- HOLD, dir = opposite: treated as a new press; immediate move in the new direction, relatch, reload counter.
- HOLD, dir = NONE: → IDLE, no move.
- Counter width $clog2(REPEAT_CYCLES); posjug2 is exactly one-hot at all times after reset.

## Timing
- Press sampled at edge N → posjug2 updated at edge N (visible cycle N+1): 1-cycle latency.
- Held press: moves at sample cycles N, N+REPEAT_CYCLES, N+2·REPEAT_CYCLES, …
- nocollision=0 sampled at edge M → Frozen=1 after edge M; a press in the same cycle is dropped.
- Release to IDLE: 1 cycle; a re-press in the next cycle moves immediately.
- clear mid-HOLD or mid-FROZEN: takes effect at the same edge; the next cycle starts from IDLE.

## Structure
- Shared package `sc_posjug2_pkg`: state enum (IDLE, HOLD, FROZEN), direction enum (NONE, LEFT, RIGHT), NUM_LANES default constant shared with the comparator.
- One sub-module: `sc_repeat_timer`, a load/decrement/zero-flag down-counter parameterised by REPEAT_CYCLES.
- Top level: FSM plus one-hot shift register with saturation.

## Test plan
Parameters for all scenarios: REPEAT_CYCLES=4, START_LANE=0, NUM_LANES=4, enable=1.
- Reset low for 2 cycles → posjug2=8'b0000_0001, Frozen=0.
- Left high for 1 cycle → posjug2=8'b0000_0010 one cycle later. Held 20 cycles → 0000_0100 at +4, 0000_1000 at +8, then stays 0000_1000 (saturates, no wrap).
- At lane 0, right pressed → posjug2 stays 0000_0001. Left+right together from lane 1 → no change, state IDLE.
- Holding left at lane 1, switch to right-only → 0000_0001 on the next cycle, with the repeat counter restarted.
- nocollision=0 and left in the same cycle at lane 2 → posjug2 stays 0000_0100, Frozen=1. Further presses are ignored. clear pulse → 0000_0001, Frozen=0.
- enable=0 while holding left → no moves. Reset low mid-HOLD → posjug2=0000_0001, IDLE on the next cycle.
